// File: rtl/ant_select_div.sv
// ant_select_div
// Receive-diversity selector for NUM_ANT antennas. Per-antenna RSSI (unsigned
// half-dB) is averaged over windows of 2**AVG_LOG2 accepted strobes. At each
// window end the strongest antenna is found by a one-antenna-per-cycle scan.
// The selector switches to it only if it beats the current antenna by more
// than HYST. Decisions are suppressed while a packet is in flight. A software
// force overrides everything. The selected antenna's I/Q sample and RSSI are
// registered onto a single output bus.
//
// Ports
//   clock             system clock
//   reset             synchronous, active-high
//   enable            0 stalls all state; output pulses forced low
//   rssi_half_db      per-antenna RSSI, antenna k at [k*RSSI_W +: RSSI_W]
//   sample_in         per-antenna samples, antenna k at [k*SAMPLE_W +: SAMPLE_W]
//   sample_in_strobe  one-cycle pulse per input sample, common to all antennas
//   pkt_busy          receiver busy; freezes selection decisions
//   force_en          software override enable
//   force_ant         forced antenna index (clamped to NUM_ANT-1)
//   sample_out        selected antenna sample
//   sample_out_strobe qualifies sample_out, one cycle after sample_in_strobe
//   rssi_out          selected antenna RSSI, registered with sample_out
//   ant_select        current antenna index
//   switch_stb        one-cycle pulse when ant_select changes
module ant_select_div #(
    parameter int  NUM_ANT  = 4,
    parameter int  SAMPLE_W = 32,
    parameter int  RSSI_W   = 11,
    parameter int  AVG_LOG2 = 4,
    parameter int  HYST     = 6,
    localparam int SEL_W    = $clog2(NUM_ANT)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_ANT*RSSI_W-1:0]   rssi_half_db,
    input  logic [NUM_ANT*SAMPLE_W-1:0] sample_in,
    input  logic                        sample_in_strobe,
    input  logic                        pkt_busy,
    input  logic                        force_en,
    input  logic [SEL_W-1:0]            force_ant,
    output logic [SAMPLE_W-1:0]         sample_out,
    output logic                        sample_out_strobe,
    output logic [RSSI_W-1:0]           rssi_out,
    output logic [SEL_W-1:0]            ant_select,
    output logic                        switch_stb
);

    localparam int               ACC_W    = RSSI_W + AVG_LOG2;
    localparam int               CNT_W    = AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ANT - 1);

    typedef enum logic [1:0] {
        S_ACC,
        S_SCAN,
        S_DECIDE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [ACC_W-1:0]    acc_q    [NUM_ANT];
    logic [RSSI_W-1:0]   avg_q    [NUM_ANT];
    logic [SEL_W-1:0]    scan_idx_q;
    logic [SEL_W-1:0]    best_idx_q;
    logic [RSSI_W-1:0]   best_avg_q;
    logic [SEL_W-1:0]    ant_select_q;
    logic [SAMPLE_W-1:0] sample_out_q;
    logic [RSSI_W-1:0]   rssi_out_q;
    logic                sample_out_strobe_q;
    logic                switch_stb_q;

    logic [RSSI_W-1:0]   rssi_a   [NUM_ANT];
    logic [SAMPLE_W-1:0] sample_a [NUM_ANT];
    logic [ACC_W-1:0]    acc_d    [NUM_ANT];
    logic [SEL_W-1:0]    force_sel_d;
    logic [RSSI_W:0]     cur_thresh_d;
    logic                better_d;
    logic                scan_take_d;

    // Unpack the flat buses and form the next accumulator values. The
    // accumulator is wide enough for a full window of maximum RSSI.
    for (genvar k = 0; k < NUM_ANT; k++) begin : g_ant
        assign rssi_a[k]   = rssi_half_db[k*RSSI_W +: RSSI_W];
        assign sample_a[k] = sample_in[k*SAMPLE_W +: SAMPLE_W];
        assign acc_d[k]    = acc_q[k] + ACC_W'(rssi_a[k]);
    end

    // Clamping is only needed when the index field can encode non-existent antennas.
    if ((1 << SEL_W) > NUM_ANT) begin : g_clamp
        assign force_sel_d = (force_ant > SEL_LAST) ? SEL_LAST : force_ant;
    end else begin : g_no_clamp
        assign force_sel_d = force_ant;
    end

    // Hysteresis threshold gets one extra bit so avg + HYST cannot wrap.
    assign cur_thresh_d = {1'b0, avg_q[ant_select_q]} + (RSSI_W + 1)'(HYST);
    assign better_d     = {1'b0, best_avg_q} > cur_thresh_d;

    // The first antenna seeds the scan; later ones win only when strictly
    // greater, so ties resolve to the lowest index.
    assign scan_take_d  = (scan_idx_q == '0) || (avg_q[scan_idx_q] > best_avg_q);

    // A decision deferred by pkt_busy is never replayed. The next window end
    // re-evaluates from fresh averages, so no separate pending flag is kept.
    // NOTE: every register below is updated with <= so all branches see the
    // values from before this edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= S_ACC;
            count_q             <= '0;
            scan_idx_q          <= '0;
            best_idx_q          <= '0;
            best_avg_q          <= '0;
            ant_select_q        <= '0;
            sample_out_q        <= '0;
            rssi_out_q          <= '0;
            sample_out_strobe_q <= 1'b0;
            switch_stb_q        <= 1'b0;
            // NOTE: these per-antenna arrays are plain flops, not RAM, so they
            // are reset to drop any partial window.
            for (int k = 0; k < NUM_ANT; k++) begin
                acc_q[k] <= '0;
                avg_q[k] <= '0;
            end
        end else if (!enable) begin
            // Everything holds; only the pulses are cleared so nothing
            // re-fires when enable returns.
            sample_out_strobe_q <= 1'b0;
            switch_stb_q        <= 1'b0;
        end else begin
            // Mux uses ant_select as it stands in the strobe cycle.
            sample_out_strobe_q <= sample_in_strobe;
            if (sample_in_strobe) begin
                sample_out_q <= sample_a[ant_select_q];
                rssi_out_q   <= rssi_a[ant_select_q];
            end

            switch_stb_q <= 1'b0;
            case (state_q)
                S_SCAN: begin
                    if (scan_take_d) begin
                        best_idx_q <= scan_idx_q;
                        best_avg_q <= avg_q[scan_idx_q];
                    end
                    if (scan_idx_q == SEL_LAST) begin
                        state_q <= S_DECIDE;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    state_q <= S_ACC;
                    if (better_d && !pkt_busy) begin
                        ant_select_q <= best_idx_q;
                        switch_stb_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Force overrides any DECIDE result in the same cycle.
            if (force_en) begin
                ant_select_q <= force_sel_d;
                switch_stb_q <= (force_sel_d != ant_select_q);
            end

            // Accumulation runs independently of the FSM; closing a window
            // latches the averages and starts a fresh scan.
            if (sample_in_strobe) begin
                if (count_q == CNT_LAST) begin
                    for (int k = 0; k < NUM_ANT; k++) begin
                        avg_q[k] <= acc_d[k][ACC_W-1:AVG_LOG2];
                        acc_q[k] <= '0;
                    end
                    count_q    <= '0;
                    state_q    <= S_SCAN;
                    scan_idx_q <= '0;
                end else begin
                    for (int k = 0; k < NUM_ANT; k++) begin
                        acc_q[k] <= acc_d[k];
                    end
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign sample_out        = sample_out_q;
    assign rssi_out          = rssi_out_q;
    assign ant_select        = ant_select_q;
    assign sample_out_strobe = sample_out_strobe_q & enable;
    assign switch_stb        = switch_stb_q & enable;

endmodule

// File: tb/tb_ant_select_div.sv
// tb_ant_select_div
// Self-checking bench for ant_select_div (NUM_ANT=4, AVG_LOG2=4, HYST=6).
// Strobes are issued every 10 cycles. A transaction-level model tracks the
// expected selection. Expected output samples go into a scoreboard queue
// when a strobe is driven and are compared when sample_out_strobe appears.
module tb_ant_select_div;

    localparam int NUM_ANT  = 4;
    localparam int SAMPLE_W = 32;
    localparam int RSSI_W   = 11;
    localparam int AVG_LOG2 = 4;
    localparam int HYST     = 6;
    localparam int SEL_W    = 2;
    localparam int WIN      = 1 << AVG_LOG2;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        enable = 1'b1;
    logic [NUM_ANT*RSSI_W-1:0]   rssi_half_db = '0;
    logic [NUM_ANT*SAMPLE_W-1:0] sample_in = '0;
    logic                        sample_in_strobe = 1'b0;
    logic                        pkt_busy = 1'b0;
    logic                        force_en = 1'b0;
    logic [SEL_W-1:0]            force_ant = '0;
    logic [SAMPLE_W-1:0]         sample_out;
    logic                        sample_out_strobe;
    logic [RSSI_W-1:0]           rssi_out;
    logic [SEL_W-1:0]            ant_select;
    logic                        switch_stb;

    ant_select_div #(
        .NUM_ANT (NUM_ANT),
        .SAMPLE_W(SAMPLE_W),
        .RSSI_W  (RSSI_W),
        .AVG_LOG2(AVG_LOG2),
        .HYST    (HYST)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .rssi_half_db     (rssi_half_db),
        .sample_in        (sample_in),
        .sample_in_strobe (sample_in_strobe),
        .pkt_busy         (pkt_busy),
        .force_en         (force_en),
        .force_ant        (force_ant),
        .sample_out       (sample_out),
        .sample_out_strobe(sample_out_strobe),
        .rssi_out         (rssi_out),
        .ant_select       (ant_select),
        .switch_stb       (switch_stb)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [SAMPLE_W-1:0] sample;
        logic [RSSI_W-1:0]   rssi;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   sw_cnt   = 0;

    // Model state
    int model_sel = 0;
    int m_cnt     = 0;
    int m_acc [NUM_ANT];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rssi_of(input int k);
        return int'(rssi_half_db[k*RSSI_W +: RSSI_W]);
    endfunction

    task automatic set_rssi(input int r0, input int r1, input int r2, input int r3);
        rssi_half_db = {RSSI_W'(r3), RSSI_W'(r2), RSSI_W'(r1), RSSI_W'(r0)};
    endtask

    task automatic model_reset();
        model_sel = 0;
        m_cnt     = 0;
        for (int k = 0; k < NUM_ANT; k++) m_acc[k] = 0;
    endtask

    // One accepted strobe in the model; returns with model_sel holding the
    // selection that will be in force from the next strobe.
    task automatic model_step();
        int avg [NUM_ANT];
        int best;
        for (int k = 0; k < NUM_ANT; k++) m_acc[k] += rssi_of(k);
        m_cnt++;
        if (m_cnt == WIN) begin
            for (int k = 0; k < NUM_ANT; k++) avg[k] = m_acc[k] / WIN;
            best = 0;
            for (int k = 1; k < NUM_ANT; k++) if (avg[k] > avg[best]) best = k;
            if (!force_en && !pkt_busy && avg[best] > avg[model_sel] + HYST) model_sel = best;
            for (int k = 0; k < NUM_ANT; k++) m_acc[k] = 0;
            m_cnt = 0;
        end
    endtask

    // Drive one strobe at the current falling edge; returns 10 cycles later.
    // On a window-closing strobe, the decision timing is checked: the old
    // value is still visible 4 cycles after the strobe edge, and the new one
    // plus its switch pulse 5 cycles after.
    task automatic strobe();
        int   m_old;
        int   m_new;
        bit   closing;
        exp_t e;
        closing = (m_cnt == WIN - 1);
        m_old   = model_sel;
        for (int k = 0; k < NUM_ANT; k++) sample_in[k*SAMPLE_W +: SAMPLE_W] = $urandom;
        sample_in_strobe = 1'b1;
        e.sample = sample_in[model_sel*SAMPLE_W +: SAMPLE_W];
        e.rssi   = rssi_half_db[model_sel*RSSI_W +: RSSI_W];
        sb_q.push_back(e);
        model_step();
        m_new = model_sel;
        @(negedge clock);
        check("out_strobe_latency", sample_out_strobe, 1);
        sample_in_strobe = 1'b0;
        if (closing) begin
            repeat (4) @(negedge clock);
            check("sel_before_decide", ant_select, m_old);
            @(negedge clock);
            check("sel_after_decide", ant_select, m_new);
            check("switch_pulse", switch_stb, m_new != m_old);
            @(negedge clock);
            check("switch_one_cycle", switch_stb, 0);
            repeat (3) @(negedge clock);
        end else begin
            repeat (9) @(negedge clock);
        end
    endtask

    task automatic finish_window();
        do strobe(); while (m_cnt != 0);
    endtask

    task automatic set_force(input bit en, input int ant, input int exp_sel);
        int old;
        old       = model_sel;
        force_en  = en;
        force_ant = SEL_W'(ant);
        if (en) model_sel = exp_sel;
        @(negedge clock);
        check("force_sel", ant_select, model_sel);
        check("force_switch", switch_stb, model_sel != old);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_ant_select", ant_select, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_rssi_out", rssi_out, 0);
        check("rst_out_strobe", sample_out_strobe, 0);
        check("rst_switch_stb", switch_stb, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    // Scoreboard consumer
    always @(negedge clock) begin
        if (!reset && sample_out_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_sample", sample_out, e.sample);
                check("sb_rssi", rssi_out, e.rssi);
            end
        end
    end

    always @(negedge clock) begin
        if (switch_stb === 1'b1) sw_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int sw_base;
        model_reset();
        @(negedge clock);
        do_reset();

        // 1: ant2 clearly strongest from reset
        set_rssi(50, 50, 100, 50);
        repeat (WIN) strobe();
        check("t1_sel", ant_select, 2);
        check("t1_switch_count", sw_cnt, 1);

        // 2: margin 4 does not switch; margin 7 does. An ignored strobe under
        // enable=0 sits in the middle of the switching window.
        set_rssi(50, 104, 100, 50);
        finish_window();
        check("t2_no_switch", ant_select, 2);
        check("t2_switch_count", sw_cnt, 1);
        set_rssi(50, 107, 100, 50);
        repeat (5) strobe();
        enable = 1'b0;
        sample_in_strobe = 1'b1;
        @(negedge clock);
        check("en0_out_strobe", sample_out_strobe, 0);
        check("en0_sel_held", ant_select, 2);
        sample_in_strobe = 1'b0;
        repeat (2) @(negedge clock);
        enable = 1'b1;
        repeat (8) @(negedge clock);
        finish_window();
        check("t2_switch", ant_select, 1);

        // 3: busy freezes decisions for 3 windows, then switch after the drop
        pkt_busy = 1'b1;
        set_rssi(50, 107, 100, 200);
        repeat (3) finish_window();
        check("t3_busy_hold", ant_select, 1);
        pkt_busy = 1'b0;
        repeat (3) strobe();
        check("t3_no_retro", ant_select, 1);
        finish_window();
        check("t3_switch", ant_select, 3);

        // 4: force, clamp, priority over busy and DECIDE, release holds
        set_force(1'b1, 0, 0);
        finish_window();
        check("t4_force_over_decide", ant_select, 0);
        set_force(1'b1, 3, 3);
        pkt_busy = 1'b1;
        set_force(1'b1, 7, 3);
        finish_window();
        check("t4_force_over_busy", ant_select, 3);
        pkt_busy = 1'b0;
        set_force(1'b1, 0, 0);
        set_force(1'b0, 0, 0);
        repeat (4) strobe();
        check("t4_release_hold", ant_select, 0);
        finish_window();
        check("t4_release_decide", ant_select, 3);

        // 5: reset at strobe 9 of a window with ant1 strongest
        set_rssi(50, 300, 50, 50);
        repeat (9) strobe();
        do_reset();
        repeat (WIN - 1) strobe();
        check("t5_no_early_decide", ant_select, 0);
        strobe();
        check("t5_decide", ant_select, 1);

        // 6: all equal -> stays 0, no pulses over 10 windows
        do_reset();
        sw_base = sw_cnt;
        set_rssi(80, 80, 80, 80);
        repeat (10) finish_window();
        check("t6_sel", ant_select, 0);
        check("t6_no_switch", sw_cnt - sw_base, 0);

        repeat (3) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
